// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: credit-based drain of a 1-cycle-latency FIFO read port into a first-word-fall-through valid/ready stream.
// Optional word counter enabled by defining WORD_COUNT_EN.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_WIDTH = 16,
  localparam int AW = $clog2(BUF_DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                  rd_clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic                  fifo_valid,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [LW-1:0]         buf_level,
  output logic                  overrun_err
`ifdef WORD_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  word_count
`endif
);
  if (BUF_DEPTH < 2 || BUF_DEPTH > 8 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0 || CNT_WIDTH < 1)
    $error("fifo_rd_stream: BUF_DEPTH must be a power of two in 2..8 and CNT_WIDTH >= 1");
  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [AW-1:0] head, tail;
  logic inflight, push, pop, full;
  logic [LW:0] need;
  assign m_valid = buf_level != '0;
  assign m_data = mem[head];
  assign pop = m_valid && m_ready;
  assign full = buf_level == LW'(BUF_DEPTH);
  // Only a solicited word is accepted; with a full buffer it needs a same-cycle pop to land.
  assign push = fifo_valid && inflight && (!full || pop);
  // A read is issued only if the word it returns is guaranteed a slot next cycle.
  assign need = {1'b0, buf_level} + (LW+1)'(inflight) + (LW+1)'(!pop);
  assign fifo_rd_en = !reset && !fifo_empty && need <= (LW+1)'(BUF_DEPTH);
  always_ff @(posedge rd_clk) begin
    if (reset) begin
      buf_level <= '0;
      head <= '0;
      tail <= '0;
      inflight <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      head <= head + AW'(pop);
      tail <= tail + AW'(push);
      buf_level <= buf_level + LW'(push) - LW'(pop);
      overrun_err <= overrun_err || (fifo_valid && full && !pop);
    end
  end
  always_ff @(posedge rd_clk)
    if (push && !reset) mem[tail] <= fifo_r_data;
`ifdef WORD_COUNT_EN
  always_ff @(posedge rd_clk)
    if (reset) word_count <= '0;
    else if (pop) word_count <= word_count + 1'b1;
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: queue-based model of the FIFO and the stream buffer, checked against the DUT every cycle.
module tb_fifo_rd_stream;
  localparam int D = 2;
  logic rd_clk = 0, reset = 1, fifo_empty = 1, fifo_valid = 0, m_ready = 0;
  logic [7:0] fifo_r_data = '0;
  logic fifo_rd_en, m_valid, overrun_err;
  logic [7:0] m_data;
  logic [1:0] buf_level;
`ifdef WORD_COUNT_EN
  logic [15:0] word_count;
`endif
  int checks = 0, errors = 0;
  logic [7:0] fq[$], bq[$], got[$], sent[$];
  bit inf_m, err_m, pend_v, inject, rnd_empty, any_rd;
  logic [7:0] pend_d;
  int rmode, tog, max_lvl;
  int unsigned popped;
  logic s_rd, s_v;
  logic [7:0] s_d;
  logic [1:0] s_lvl;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream dut (
    .rd_clk(rd_clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_valid(fifo_valid),
    .fifo_r_data(fifo_r_data), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .buf_level(buf_level), .overrun_err(overrun_err)
`ifdef WORD_COUNT_EN
    , .word_count(word_count)
`endif
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic step(input bit rst = 1'b0);
    bit pop, erd;
    @(negedge rd_clk);
    reset = rst;
    fifo_empty = (fq.size() == 0) || (rnd_empty && $urandom_range(3) == 0);
    tog++;
    m_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'b0 : rmode == 2 ? 1'($urandom_range(1)) : 1'(tog[0]);
    fifo_valid = pend_v;
    fifo_r_data = pend_d;
    #1;
    pop = bq.size() != 0 && m_ready;
    erd = !rst && !fifo_empty && (bq.size() + int'(inf_m) + (pop ? 0 : 1) <= D);
    s_rd = fifo_rd_en; s_v = m_valid; s_d = m_data; s_lvl = buf_level;
    chk("fifo_rd_en", fifo_rd_en, erd);
    chk("m_valid", m_valid, bq.size() != 0);
    chk("buf_level", buf_level, bq.size());
    chk("overrun_err", overrun_err, err_m);
    if (bq.size() != 0) chk("m_data", m_data, bq[0]);
`ifdef WORD_COUNT_EN
    chk("word_count", word_count, popped & 32'hFFFF);
`endif
    if (int'(buf_level) > max_lvl) max_lvl = buf_level;
    if (fifo_rd_en) any_rd = 1;
    @(posedge rd_clk);
    if (rst) begin
      bq.delete(); fq.delete();
      inf_m = 0; err_m = 0; popped = 0;
      pend_v = inject; pend_d = 8'hEE; inject = 0;
    end else begin
      if (fifo_valid && bq.size() == D && !pop) err_m = 1;
      if (pop) begin got.push_back(bq.pop_front()); popped++; end
      if (fifo_valid && inf_m && bq.size() < D) bq.push_back(fifo_r_data);
      inf_m = erd;
      pend_v = erd;
      pend_d = erd ? fq.pop_front() : 8'($urandom);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [7:0] lrd[8], lv[8], ld[8];
    rmode = 0; tog = 0; rnd_empty = 0;
    step(1); step(1);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_buf_level", buf_level, 0);
    chk("rst_overrun", overrun_err, 0);
    // basic drain
    fq = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 8; i++) begin step(); lrd[i] = 8'(s_rd); lv[i] = 8'(s_v); ld[i] = s_d; end
    chk("drain_rd0", lrd[0], 1); chk("drain_rd1", lrd[1], 1);
    chk("drain_rd2", lrd[2], 1); chk("drain_rd3", lrd[3], 0);
    chk("drain_v1", lv[1], 0);
    chk("drain_d2", ld[2], 8'h11); chk("drain_d3", ld[3], 8'h22); chk("drain_d4", ld[4], 8'h33);
    chk("drain_v4", lv[4], 1); chk("drain_v5", lv[5], 0);
    // backpressure
    got.delete(); rmode = 1;
    fq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run(10);
    chk("bp_level", s_lvl, 2); chk("bp_data", s_d, 8'h11); chk("bp_rd", s_rd, 0);
    rmode = 0; run(15);
    chk("bp_count", got.size(), 5);
    for (int i = 0; i < 5; i++) chk("bp_order", got[i], 8'(8'h11 * (i + 1)));
    // empty fifo
    any_rd = 0; rmode = 2; run(20);
    chk("empty_no_rd", any_rd, 0);
    // alternating ready
    got.delete(); max_lvl = 0; rmode = 3; tog = 0;
    for (int i = 0; i < 8; i++) fq.push_back(8'(i));
    run(30);
    chk("alt_count", got.size(), 8);
    for (int i = 0; i < 8; i++) chk("alt_order", got[i], i);
    chk("alt_max_level", max_lvl <= 2, 1);
    // reset mid-stream with a stale fifo_valid afterwards
    rmode = 1;
    fq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    run(6);
    chk("mid_level", s_lvl, 2);
    inject = 1;
    step(1);
    #1; chk("mid_rst_valid", m_valid, 0); chk("mid_rst_level", buf_level, 0);
    rmode = 2; step();
    #1; chk("late_level", buf_level, 0); chk("late_valid", m_valid, 0); chk("late_err", overrun_err, 0);
    // unsolicited word into a full buffer
    rmode = 1; fq = '{8'hB1, 8'hB2, 8'hB3};
    run(6);
    pend_v = 1; pend_d = 8'hAA;
    step();
    #1; chk("ovr_set", overrun_err, 1); chk("ovr_level", buf_level, 2);
    run(5);
    step(1); step();
    #1; chk("ovr_clear", overrun_err, 0);
    // randomized traffic
    got.delete(); sent.delete(); rnd_empty = 1; rmode = 2;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(2) != 0) begin
        logic [7:0] w;
        w = 8'($urandom);
        fq.push_back(w); sent.push_back(w);
      end
      step();
    end
    rnd_empty = 0; rmode = 0;
    run(2000);
    chk("rnd_count", got.size(), sent.size());
    for (int i = 0; i < sent.size() && i < got.size(); i++)
      if (got[i] !== sent[i]) chk("rnd_order", got[i], sent[i]);
`ifdef WORD_COUNT_EN
    step(1);
    begin
      int fed = 0;
      while (popped < 70000) begin
        if (fed < 70000 && fq.size() < 4) begin fq.push_back(8'(fed)); fed++; end
        step();
      end
    end
    #1; chk("word_count_wrap", word_count, 4464);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
